// File: rtl/spike_rate_decoder.sv
// Spike-train decoder: counts spikes per programmable back-to-back window and
// tracks the latest inter-spike interval, publishing both over valid/ready.
module spike_rate_decoder #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned WIN_W = 8,
    parameter int unsigned ISI_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             spike_in,
    input  logic [WIN_W-1:0] window_len,
    output logic [CNT_W-1:0] rate_out,
    output logic [ISI_W-1:0] isi_out,
    output logic             valid,
    input  logic             ready,
    output logic             overrun,
    output logic             sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [ISI_W-1:0] ISI_MAX = '1;

    typedef enum logic {
        IDLE,
        COUNT
    } state_e;

    state_e             state_q;
    logic [WIN_W-1:0]   win_len_q;
    logic [WIN_W-1:0]   win_cnt_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               sat_q;
    logic [ISI_W-1:0]   isi_cnt_q;
    logic [ISI_W-1:0]   isi_q;
    logic               armed_q;

    logic [CNT_W-1:0]   cnt_d;
    logic               sat_d;
    logic [ISI_W-1:0]   isi_cnt_d;
    logic [ISI_W-1:0]   isi_d;
    logic [WIN_W-1:0]   win_len_d;
    logic               win_last;
    logic               win_end;

    // Next values of the window accumulator and the free-running ISI tracker
    always_comb begin
        cnt_d     = cnt_q;
        sat_d     = sat_q;
        isi_cnt_d = isi_cnt_q;
        isi_d     = isi_q;
        win_len_d = window_len;
        if (spike_in) begin
            if (cnt_q == CNT_MAX) sat_d = 1'b1;
            else                  cnt_d = cnt_q + CNT_W'(1);
        end
        if (spike_in) begin
            isi_cnt_d = ISI_W'(1);
            if (armed_q) isi_d = isi_cnt_q;
        end else if (isi_cnt_q != ISI_MAX) begin
            isi_cnt_d = isi_cnt_q + ISI_W'(1);
        end
        if (window_len == '0) win_len_d = WIN_W'(1);
        win_last = (win_cnt_q == (win_len_q - WIN_W'(1)));
        win_end  = (state_q == COUNT) && en && win_last;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            win_len_q <= '0;
            win_cnt_q <= '0;
            cnt_q     <= '0;
            sat_q     <= 1'b0;
            isi_cnt_q <= '0;
            isi_q     <= '0;
            armed_q   <= 1'b0;
            rate_out  <= '0;
            isi_out   <= '0;
            valid     <= 1'b0;
            overrun   <= 1'b0;
            sat       <= 1'b0;
        end else begin
            isi_cnt_q <= isi_cnt_d;
            isi_q     <= isi_d;
            if (spike_in) armed_q <= 1'b1;

            case (state_q)
                IDLE: begin
                    if (en) begin
                        win_len_q <= win_len_d;
                        win_cnt_q <= '0;
                        cnt_q     <= '0;
                        sat_q     <= 1'b0;
                        state_q   <= COUNT;
                    end
                end
                COUNT: begin
                    if (!en) begin
                        state_q <= IDLE;
                    end else if (win_last) begin
                        win_len_q <= win_len_d;
                        win_cnt_q <= '0;
                        cnt_q     <= '0;
                        sat_q     <= 1'b0;
                    end else begin
                        win_cnt_q <= win_cnt_q + WIN_W'(1);
                        cnt_q     <= cnt_d;
                        sat_q     <= sat_d;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // A fresh result wins over a same-edge consume; unconsumed overwrite is sticky
            if (win_end) begin
                rate_out <= cnt_d;
                sat      <= sat_d;
                isi_out  <= isi_d;
                valid    <= 1'b1;
                if (valid && !ready) overrun <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder (CNT_W=7 build) with hand-computed expectations.
module tb_spike_rate_decoder;

    localparam int unsigned CNT_W = 7;
    localparam int unsigned WIN_W = 8;
    localparam int unsigned ISI_W = 8;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic             spike_in;
    logic [WIN_W-1:0] window_len;
    logic [CNT_W-1:0] rate_out;
    logic [ISI_W-1:0] isi_out;
    logic             valid;
    logic             ready;
    logic             overrun;
    logic             sat;

    int vectors;
    int errs;

    spike_rate_decoder #(.CNT_W(CNT_W), .WIN_W(WIN_W), .ISI_W(ISI_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .spike_in   (spike_in),
        .window_len (window_len),
        .rate_out   (rate_out),
        .isi_out    (isi_out),
        .valid      (valid),
        .ready      (ready),
        .overrun    (overrun),
        .sat        (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        vectors    = 0;
        errs       = 0;
        rst_n      = 1'b0;
        en         = 1'b0;
        spike_in   = 1'b0;
        window_len = '0;
        ready      = 1'b0;
        tick();
        tick();
        chk("rst_rate", 32'(rate_out), 0);
        chk("rst_isi", 32'(isi_out), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_sat", 32'(sat), 0);
        rst_n = 1'b1;
        tick();

        // Window of 10 with spikes on cycles 1,4,7
        en = 1'b1;
        window_len = 8'd10;
        tick();
        for (int c = 0; c < 10; c++) begin
            spike_in = (c == 1 || c == 4 || c == 7);
            tick();
            if (c == 8) chk("w10_not_yet", 32'(valid), 0);
        end
        spike_in = 1'b0;
        chk("w10_valid", 32'(valid), 1);
        chk("w10_rate", 32'(rate_out), 3);
        chk("w10_isi", 32'(isi_out), 3);
        chk("w10_sat", 32'(sat), 0);
        chk("w10_overrun", 32'(overrun), 0);
        ready = 1'b1;
        tick();
        chk("w10_consume", 32'(valid), 0);
        en = 1'b0;
        tick();

        // window_len=0 acts as 1: a result every cycle with ready high
        window_len = 8'd0;
        spike_in = 1'b1;
        en = 1'b1;
        tick();
        chk("w0_first", 32'(valid), 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("w0_valid", 32'(valid), 1);
            chk("w0_rate", 32'(rate_out), 1);
            chk("w0_isi", 32'(isi_out), 1);
            chk("w0_overrun", 32'(overrun), 0);
        end
        en = 1'b0;
        spike_in = 1'b0;
        tick();
        chk("w0_drain", 32'(valid), 0);

        // 255-cycle window saturates the 7-bit count, then an empty window
        window_len = 8'd255;
        spike_in = 1'b1;
        en = 1'b1;
        tick();
        for (int i = 0; i < 255; i++) begin
            tick();
            if (i == 253) chk("w255_not_yet", 32'(valid), 0);
        end
        spike_in = 1'b0;
        chk("w255_valid", 32'(valid), 1);
        chk("w255_rate", 32'(rate_out), 127);
        chk("w255_sat", 32'(sat), 1);
        chk("w255_isi", 32'(isi_out), 1);
        for (int i = 0; i < 255; i++) begin
            tick();
            if (i == 0) chk("w255_consume", 32'(valid), 0);
        end
        chk("wz_valid", 32'(valid), 1);
        chk("wz_rate", 32'(rate_out), 0);
        chk("wz_sat", 32'(sat), 0);
        chk("wz_isi", 32'(isi_out), 1);
        en = 1'b0;
        tick();
        ready = 1'b0;

        // Two window ends with ready low -> overwrite and sticky overrun
        window_len = 8'd4;
        en = 1'b1;
        tick();
        for (int c = 0; c < 4; c++) begin
            spike_in = (c == 0 || c == 2);
            tick();
        end
        chk("ovA_valid", 32'(valid), 1);
        chk("ovA_rate", 32'(rate_out), 2);
        chk("ovA_isi", 32'(isi_out), 2);
        chk("ovA_overrun", 32'(overrun), 0);
        for (int c = 0; c < 4; c++) begin
            spike_in = (c == 1);
            tick();
            if (c == 2) chk("ovB_hold_rate", 32'(rate_out), 2);
        end
        spike_in = 1'b0;
        chk("ovB_valid", 32'(valid), 1);
        chk("ovB_rate", 32'(rate_out), 1);
        chk("ovB_isi", 32'(isi_out), 3);
        chk("ovB_overrun", 32'(overrun), 1);
        en = 1'b0;
        ready = 1'b1;
        tick();
        chk("ov_consume", 32'(valid), 0);
        chk("ov_sticky", 32'(overrun), 1);

        // Abort at window cycle 5 after two spikes, restart 3 cycles later
        window_len = 8'd10;
        en = 1'b1;
        tick();
        for (int c = 0; c < 5; c++) begin
            spike_in = (c == 1 || c == 3);
            tick();
        end
        spike_in = 1'b0;
        en = 1'b0;
        tick();
        chk("abort_novalid", 32'(valid), 0);
        tick();
        tick();
        tick();
        chk("abort_idle_novalid", 32'(valid), 0);
        en = 1'b1;
        tick();
        for (int c = 0; c < 10; c++) begin
            spike_in = (c == 6);
            tick();
            if (c == 8) chk("restart_not_yet", 32'(valid), 0);
        end
        spike_in = 1'b0;
        chk("restart_valid", 32'(valid), 1);
        chk("restart_rate", 32'(rate_out), 1);
        chk("restart_isi", 32'(isi_out), 13);
        chk("restart_overrun", 32'(overrun), 1);
        en = 1'b0;
        tick();

        // Spikes 300 cycles apart while idle -> saturated ISI
        spike_in = 1'b1;
        tick();
        spike_in = 1'b0;
        for (int i = 0; i < 299; i++) tick();
        spike_in = 1'b1;
        tick();
        spike_in = 1'b0;
        window_len = 8'd1;
        en = 1'b1;
        tick();
        window_len = 8'd10;
        tick();
        chk("isi_sat_valid", 32'(valid), 1);
        chk("isi_sat_isi", 32'(isi_out), 255);
        chk("isi_sat_rate", 32'(rate_out), 0);
        ready = 1'b0;
        spike_in = 1'b1;
        tick();
        tick();
        tick();

        // Asynchronous reset mid-window
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_rate", 32'(rate_out), 0);
        chk("arst_isi", 32'(isi_out), 0);
        chk("arst_valid", 32'(valid), 0);
        chk("arst_overrun", 32'(overrun), 0);
        chk("arst_sat", 32'(sat), 0);
        spike_in = 1'b0;
        en = 1'b0;
        tick();
        rst_n = 1'b1;
        window_len = 8'd2;
        en = 1'b1;
        spike_in = 1'b1;
        tick();
        tick();
        chk("post_rst_not_yet", 32'(valid), 0);
        tick();
        chk("post_rst_valid", 32'(valid), 1);
        chk("post_rst_rate", 32'(rate_out), 2);
        chk("post_rst_isi", 32'(isi_out), 1);
        chk("post_rst_overrun", 32'(overrun), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/spike_rate_decoder.md
Name: spike_rate_decoder

Overview:
Converts a single-bit spike train from a LIF neuron back into numeric values. It is the decoding end of the current-to-spike path: the LIF encodes an input current as spike rate, and this block recovers a spike count per programmable window plus the most recent inter-spike interval (ISI). Results go to a downstream consumer (readout/uo_out mux or the STDP debug path) over a valid/ready handshake. Windows run back-to-back with no dead cycles.

Parameters:
CNT_W, 8, width of spike count and rate_out
WIN_W, 8, width of window_len and internal window counter
ISI_W, 8, width of ISI counter and isi_out

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
en  input  1  run enable; low aborts the current window
spike_in  input  1  spike pulse from LIF (one spike per cycle high)
window_len  input  WIN_W  window length in cycles; sampled at window start; 0 treated as 1
rate_out  output  CNT_W  spike count of last completed window
isi_out  output  ISI_W  cycles between the last two spikes, saturating
valid  output  1  rate_out/isi_out hold an unconsumed result
ready  input  1  consumer accepts result when valid&ready at clk edge
overrun  output  1  sticky: a result was overwritten before consumption
sat  output  1  rate_out saturated in the reported window

Behaviour:
- One clock. Reset is asynchronous and active-low (rst_n). All state updates on rising clk.
- Reset values: rate_out=0, isi_out=0, valid=0, overrun=0, sat=0, FSM=IDLE, counters=0, ISI-armed flag=0.
- FSM states:
  - IDLE: no counting. On an edge with en=1, latch window_len into win_len_q (0 becomes 1), clear spike count and window counter, then go to COUNT. The next cycle is window cycle 0.
  - COUNT: each cycle, increment the window counter and add spike_in to the spike count.
    - The spike count saturates at 2^CNT_W-1. Saturation sets an internal sat_q.
    - On the edge closing cycle win_len_q-1: load rate_out with the final count (including that cycle's spike), load sat from sat_q, and set valid=1.
    - In the same edge: re-sample window_len, clear the counters and sat_q, and stay in COUNT. Windows are back-to-back with no gap.
  - en=0 on any edge in COUNT: go to IDLE and discard the partial window. Held results and valid are unaffected.
- Handshake:
  - valid&ready at an edge clears valid, unless a new result loads at the same edge. In that case valid stays 1, the new data loads, and overrun is not set.
  - A window completing while valid=1 and ready=0: overwrite rate_out/sat/isi_out, keep valid=1, set overrun=1.
  - overrun clears only on reset.
  - Outputs are stable while valid=1 and ready=0, until the next window end.
- ISI:
  - An ISI counter runs continuously in both IDLE and COUNT, saturating at 2^ISI_W-1.
  - On a spike: if the armed flag is set, capture the counter into isi_q. Then reset the counter to 1 and set armed.
  - isi_out loads from isi_q only at window end, together with rate_out.
  - Until two spikes have occurred since reset, isi_q=0.
- Simultaneous events:
  - A spike on the final window cycle counts in the closing window.
  - A spike and an ISI capture in the same cycle as window end: isi_out takes the updated isi_q.
- Latency: valid rises on the edge ending window cycle win_len_q-1. It is visible 1 cycle after the last sampled spike cycle.
- Mid-operation reset: immediate return to reset values, regardless of FSM state or handshake.

Test Plan:
- Reset then en=1, window_len=10, spike_in high on cycles 1,4,7 -> valid rises after the 10th window cycle; rate_out=3, isi_out=3, sat=0, overrun=0.
- window_len=0, spike_in=1 constantly, ready=1 -> a result every cycle with rate_out=1, valid held high continuously, no overrun.
- window_len=255, spike_in=1 constantly, CNT_W=7 build -> rate_out=127, sat=1; the next window with no spikes gives rate_out=0, sat=0.
- ready=0 across two window ends with window_len=4, spikes 2 then 1 -> rate_out=1, valid=1, overrun=1. Raising ready for one cycle clears valid; overrun stays 1.
- en dropped at window cycle 5 of 10 after 2 spikes, re-raised 3 cycles later -> no result from the aborted window; the next full window reports only its own spikes.
- Spikes 300 cycles apart with ISI_W=8 -> isi_out=255 (saturated). Asserting rst_n=0 mid-window -> all outputs 0 asynchronously, FSM in IDLE.
